// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix multiply engine.
package matmul_pkg;

  // Default configuration widths (MAX_SIZE=32, 8-bit elements).
  localparam int DEF_MAX_SIZE = 32;
  localparam int DEF_ELEM_W   = 8;
  localparam int ADDR_W       = $clog2(DEF_MAX_SIZE);
  localparam int DIM_W        = ADDR_W + 1;
  localparam int ACC_W        = 2 * DEF_ELEM_W + ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    MAC,
    EMIT,
    FIN
  } state_t;

  // Row/column address width for a given maximum dimension.
  function automatic int addr_w(input int max_size);
    return $clog2(max_size);
  endfunction

  // Accumulator wide enough for max_size full-scale products.
  function automatic int acc_w(input int elem_w, input int max_size);
    return 2 * elem_w + $clog2(max_size) + 1;
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Control, loader and compiler signals of the matmul engine.
interface matmul_if #(
  parameter int MAX_SIZE         = 32,
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int OUT_WIDTH        = 8
) ();
  import matmul_pkg::*;

  localparam int AW = addr_w(MAX_SIZE);

  // control
  logic                               start;
  logic                               complete;
  logic [AW:0]                        rows_a;
  logic [AW:0]                        cols_b;
  logic [AW:0]                        inner_k;
  logic                               done;
  logic                               busy;
  // loader request/response
  logic                               new_request;
  logic [AW-1:0]                      row_req;
  logic [AW-1:0]                      col_req;
  logic                               val_rows;
  logic [AW-1:0]                      row_in;
  logic [AW-1:0]                      col_in;
  logic [MAX_SIZE*MAX_ELEMENT_SIZE-1:0] matA_row;
  logic [MAX_SIZE*MAX_ELEMENT_SIZE-1:0] matB_col;
  // result stream
  logic                               valid_out;
  logic [AW-1:0]                      row_out;
  logic [AW-1:0]                      col_out;
  logic [OUT_WIDTH-1:0]               matrix_val;

  modport master (
    input  start, complete, rows_a, cols_b, inner_k,
    input  val_rows, row_in, col_in, matA_row, matB_col,
    output new_request, row_req, col_req,
    output valid_out, row_out, col_out, matrix_val, done, busy
  );

  modport slave (
    output start, complete, rows_a, cols_b, inner_k,
    output val_rows, row_in, col_in, matA_row, matB_col,
    input  new_request, row_req, col_req,
    input  valid_out, row_out, col_out, matrix_val, done, busy
  );

endinterface

// File: rtl/matmul_engine_mac_lanes.sv
// LANES-wide unsigned multiply-add over elements base..base+LANES-1;
// elements at or beyond inner_k contribute zero.
module mac_lanes import matmul_pkg::*; #(
  parameter int MAX_SIZE         = 32,
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int LANES            = 4,
  parameter int SUM_W            = 22
) (
  input  logic [MAX_SIZE*MAX_ELEMENT_SIZE-1:0] a_row,
  input  logic [MAX_SIZE*MAX_ELEMENT_SIZE-1:0] b_col,
  input  logic [$clog2(MAX_SIZE):0]            base,
  input  logic [$clog2(MAX_SIZE):0]            inner_k,
  output logic [SUM_W-1:0]                     sum
);
  localparam int E  = MAX_ELEMENT_SIZE;
  localparam int AW = addr_w(MAX_SIZE);
  localparam int DW = AW + 1;

  logic [LANES-1:0][2*E-1:0] prod;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] idx;
    logic [E-1:0]  a_e;
    logic [E-1:0]  b_e;
    // base is a multiple of LANES below MAX_SIZE, so idx never leaves the row
    assign idx     = base + DW'(l);
    assign a_e     = a_row[int'(idx[AW-1:0])*E +: E];
    assign b_e     = b_col[int'(idx[AW-1:0])*E +: E];
    assign prod[l] = (idx < inner_k) ? (2*E)'(a_e) * (2*E)'(b_e) : '0;
  end

  // adder tree over the lane products
  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) sum = sum + SUM_W'(prod[l]);
  end

endmodule

// File: rtl/matmul_engine.sv
// Matrix multiply engine: requests A row / B column pairs from the loader,
// forms each dot product LANES MACs per cycle, emits elements row-major,
// then pulses done.
module matmul_engine import matmul_pkg::*; #(
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_SIZE         = 32,
  parameter int LANES            = 4,
  parameter int OUT_WIDTH        = 8,
  parameter int SATURATE         = 1
) (
  input logic      clk,
  input logic      rst,
  matmul_if.master bus
);
  localparam int E     = MAX_ELEMENT_SIZE;
  localparam int AW    = addr_w(MAX_SIZE);
  localparam int DW    = AW + 1;
  localparam int ACCW  = acc_w(E, MAX_SIZE);
  localparam int ROW_W = MAX_SIZE * E;

  state_t                state_q, state_d;
  logic [DW-1:0]         rows_q, rows_d;
  logic [DW-1:0]         cols_q, cols_d;
  logic [DW-1:0]         k_q, k_d;
  logic [AW-1:0]         r_q, r_d;
  logic [AW-1:0]         c_q, c_d;
  logic [DW-1:0]         j_q, j_d;
  logic [ACCW-1:0]       acc_q, acc_d;
  logic [ROW_W-1:0]      a_q, a_d;
  logic [ROW_W-1:0]      b_q, b_d;
  logic                  new_request_q, new_request_d;
  logic [AW-1:0]         row_req_q, row_req_d;
  logic [AW-1:0]         col_req_q, col_req_d;
  logic                  valid_out_q, valid_out_d;
  logic [AW-1:0]         row_out_q, row_out_d;
  logic [AW-1:0]         col_out_q, col_out_d;
  logic [OUT_WIDTH-1:0]  matrix_val_q, matrix_val_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [ACCW-1:0]       lane_sum;

  mac_lanes #(
    .MAX_SIZE         (MAX_SIZE),
    .MAX_ELEMENT_SIZE (E),
    .LANES            (LANES),
    .SUM_W            (ACCW)
  ) u_mac (
    .a_row   (a_q),
    .b_col   (b_q),
    .base    (j_q),
    .inner_k (k_q),
    .sum     (lane_sum)
  );

  // clamp to all ones or keep the low bits, depending on SATURATE
  function automatic logic [OUT_WIDTH-1:0] fit(input logic [ACCW-1:0] v);
    if (SATURATE != 0 && |v[ACCW-1:OUT_WIDTH]) return '1;
    return v[OUT_WIDTH-1:0];
  endfunction

  // next-state, counter and registered-output logic
  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    k_d          = k_q;
    r_d          = r_q;
    c_d          = c_q;
    j_d          = j_q;
    acc_d        = acc_q;
    a_d          = a_q;
    b_d          = b_q;
    new_request_d = 1'b0;
    row_req_d    = row_req_q;
    col_req_d    = col_req_q;
    valid_out_d  = 1'b0;
    row_out_d    = row_out_q;
    col_out_d    = col_out_q;
    matrix_val_d = matrix_val_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.complete) begin
          rows_d = bus.rows_a;
          cols_d = bus.cols_b;
          k_d    = bus.inner_k;
          r_d    = '0;
          c_d    = '0;
          // an empty product still completes with a done pulse
          if (bus.rows_a == '0 || bus.cols_b == '0 || bus.inner_k == '0) state_d = FIN;
          else                                                           state_d = REQ;
        end
      end
      REQ: begin
        new_request_d = 1'b1;
        row_req_d     = r_q;
        col_req_d     = c_q;
        state_d       = WAIT;
      end
      WAIT: begin
        // only the response for the outstanding (r, c) is taken
        if (bus.val_rows && bus.row_in == r_q && bus.col_in == c_q) begin
          a_d     = bus.matA_row;
          b_d     = bus.matB_col;
          acc_d   = '0;
          j_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + lane_sum;
        j_d   = j_q + DW'(LANES);
        if (j_q + DW'(LANES) >= k_q) state_d = EMIT;
      end
      EMIT: begin
        valid_out_d  = 1'b1;
        row_out_d    = r_q;
        col_out_d    = c_q;
        matrix_val_d = fit(acc_q);
        state_d      = REQ;
        if ({1'b0, c_q} == cols_q - DW'(1)) begin
          c_d = '0;
          if ({1'b0, r_q} == rows_q - DW'(1)) state_d = FIN;
          else                                r_d     = r_q + AW'(1);
        end else begin
          c_d = c_q + AW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rows_q        <= '0;
      cols_q        <= '0;
      k_q           <= '0;
      r_q           <= '0;
      c_q           <= '0;
      j_q           <= '0;
      acc_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      new_request_q <= 1'b0;
      row_req_q     <= '0;
      col_req_q     <= '0;
      valid_out_q   <= 1'b0;
      row_out_q     <= '0;
      col_out_q     <= '0;
      matrix_val_q  <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      k_q           <= k_d;
      r_q           <= r_d;
      c_q           <= c_d;
      j_q           <= j_d;
      acc_q         <= acc_d;
      a_q           <= a_d;
      b_q           <= b_d;
      new_request_q <= new_request_d;
      row_req_q     <= row_req_d;
      col_req_q     <= col_req_d;
      valid_out_q   <= valid_out_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
      matrix_val_q  <= matrix_val_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.new_request = new_request_q;
  assign bus.row_req     = row_req_q;
  assign bus.col_req     = col_req_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.row_out     = row_out_q;
  assign bus.col_out     = col_out_q;
  assign bus.matrix_val  = matrix_val_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench: one saturating and one truncating engine share stimulus
// from a loader model; results are compared against hand-computed tables.
module tb_matmul_engine;
  import matmul_pkg::*;

  localparam int N  = DEF_MAX_SIZE;
  localparam int E  = DEF_ELEM_W;
  localparam int AW = ADDR_W;
  localparam int DW = DIM_W;
  localparam int NV = 10;

  typedef struct {
    int              rows;
    int              cols;
    int              k;
    int              mode;
    bit              trunc;
    bit              mis;
    int              n;
    logic [3:0][7:0] ev;
    int              lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start, complete, val_rows;
  logic [DW-1:0] rows_a, cols_b, inner_k;
  logic [AW-1:0] row_in, col_in;
  logic [N*E-1:0] matA_row, matB_col;

  always #5 clk = ~clk;

  matmul_if #(.MAX_SIZE(N), .MAX_ELEMENT_SIZE(E), .OUT_WIDTH(8)) bus_s ();
  matmul_if #(.MAX_SIZE(N), .MAX_ELEMENT_SIZE(E), .OUT_WIDTH(8)) bus_t ();

  assign bus_s.start = start;     assign bus_t.start = start;
  assign bus_s.complete = complete; assign bus_t.complete = complete;
  assign bus_s.rows_a = rows_a;   assign bus_t.rows_a = rows_a;
  assign bus_s.cols_b = cols_b;   assign bus_t.cols_b = cols_b;
  assign bus_s.inner_k = inner_k; assign bus_t.inner_k = inner_k;
  assign bus_s.val_rows = val_rows; assign bus_t.val_rows = val_rows;
  assign bus_s.row_in = row_in;   assign bus_t.row_in = row_in;
  assign bus_s.col_in = col_in;   assign bus_t.col_in = col_in;
  assign bus_s.matA_row = matA_row; assign bus_t.matA_row = matA_row;
  assign bus_s.matB_col = matB_col; assign bus_t.matB_col = matB_col;

  matmul_engine #(.MAX_ELEMENT_SIZE(E), .MAX_SIZE(N), .LANES(4), .OUT_WIDTH(8), .SATURATE(1))
    u_sat (.clk(clk), .rst(rst), .bus(bus_s));
  matmul_engine #(.MAX_ELEMENT_SIZE(E), .MAX_SIZE(N), .LANES(4), .OUT_WIDTH(8), .SATURATE(0))
    u_trn (.clk(clk), .rst(rst), .bus(bus_t));

  logic [63:0] outs_s, outs_t;
  assign outs_s = 64'({bus_s.new_request, bus_s.row_req, bus_s.col_req, bus_s.valid_out,
                       bus_s.row_out, bus_s.col_out, bus_s.matrix_val, bus_s.done, bus_s.busy});
  assign outs_t = 64'({bus_t.new_request, bus_t.row_req, bus_t.col_req, bus_t.valid_out,
                       bus_t.row_out, bus_t.col_out, bus_t.matrix_val, bus_t.done, bus_t.busy});

  int n_vec = 0;
  int n_bad = 0;
  int res_row [16];
  int res_col [16];
  int res_val [16];
  int res_lat [16];
  int nreq_g, dones_g;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // A[r][e] per test mode
  function automatic logic [7:0] a_el(input int mode, input int r, input int e);
    case (mode)
      0: return (r == e) ? 8'd1 : 8'd0;
      1: return 8'd255;
      2: return 8'd1;
      3: return 8'(r + 1);
      4: return 8'd15;
      default: return 8'd0;
    endcase
  endfunction

  // element e of B column c per test mode (mode 0: B = [[1,2],[3,4]])
  function automatic logic [7:0] b_el(input int mode, input int c, input int e);
    case (mode)
      0: return (e < 2) ? 8'(e * 2 + c + 1) : 8'd0;
      1: return 8'd255;
      2: return 8'(e + 1);
      3: return 8'(c + 1);
      4: return 8'd17;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [N*E-1:0] pack_a(input int mode, input int r);
    logic [N*E-1:0] v;
    for (int e = 0; e < N; e++) v[e*E +: E] = a_el(mode, r, e);
    return v;
  endfunction

  function automatic logic [N*E-1:0] pack_b(input int mode, input int c);
    logic [N*E-1:0] v;
    for (int e = 0; e < N; e++) v[e*E +: E] = b_el(mode, c, e);
    return v;
  endfunction

  // Start one multiply and act as the loader (3-cycle response latency).
  // With do_rst, reset is raised two cycles into the MAC of the 2nd element.
  task automatic run_case(input vec_t v, input bit do_rst, output int nres);
    int cnt, rr, cc, resp_cyc, nresp, tail, rst_at;
    bit pend, mis_left;
    pend = 0; mis_left = v.mis; nres = 0; nreq_g = 0; dones_g = 0;
    cnt = 0; rr = 0; cc = 0; resp_cyc = 0; nresp = 0; tail = 0; rst_at = -1;
    rows_a = DW'(v.rows); cols_b = DW'(v.cols); inner_k = DW'(v.k);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (bus_s.new_request) begin
        pend = 1; cnt = 3; rr = int'(bus_s.row_req); cc = int'(bus_s.col_req); nreq_g++;
      end
      if (bus_s.valid_out) begin
        if (nres < 16) begin
          res_row[nres] = int'(bus_s.row_out);
          res_col[nres] = int'(bus_s.col_out);
          res_val[nres] = v.trunc ? int'(bus_t.matrix_val) : int'(bus_s.matrix_val);
          res_lat[nres] = cyc - resp_cyc;
        end
        nres++;
      end
      if (bus_s.done) dones_g++;
      if (dones_g > 0) begin
        if (tail == 4) break;
        tail++;
      end
      @(posedge clk); #1;
      val_rows = 1'b0;
      start    = 1'b0;
      if (rst_at == cyc) begin
        rst = 1'b1;
        break;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          val_rows = 1'b1;
          row_in   = AW'(rr);
          if (mis_left) begin
            // wrong column with junk data, plus a start that must be ignored
            col_in   = AW'(cc ^ 1);
            matA_row = {N{8'h09}};
            matB_col = {N{8'h09}};
            start = 1'b1; rows_a = DW'(1); cols_b = DW'(1);
            mis_left = 0; cnt = 4;
          end else begin
            col_in   = AW'(cc);
            matA_row = pack_a(v.mode, rr);
            matB_col = pack_b(v.mode, cc);
            pend = 0; resp_cyc = cyc; nresp++;
            if (do_rst && nresp == 2) rst_at = cyc + 2;
          end
        end
      end
    end
    val_rows = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int id);
    int n;
    run_case(v, 1'b0, n);
    chk($sformatf("v%0d_count", id), n, v.n);
    chk($sformatf("v%0d_reqs", id), nreq_g, v.n);
    chk($sformatf("v%0d_done", id), dones_g, 1);
    for (int i = 0; i < v.n && i < n && i < 16; i++) begin
      chk($sformatf("v%0d_e%0d_row", id, i), res_row[i], i / v.cols);
      chk($sformatf("v%0d_e%0d_col", id, i), res_col[i], i % v.cols);
      chk($sformatf("v%0d_e%0d_val", id, i), res_val[i], v.ev[i]);
      chk($sformatf("v%0d_e%0d_lat", id, i), res_lat[i], v.lat);
    end
  endtask

  initial begin
    int act, done_at, n;
    //          rows cols k  mode trunc mis n  expected (last..first)            lat
    vt[0] = '{2, 2, 2,  0, 1'b0, 1'b0, 4, {8'd4, 8'd3, 8'd2, 8'd1},     4};
    vt[1] = '{1, 1, 32, 1, 1'b0, 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'd255},   11};
    vt[2] = '{1, 1, 32, 1, 1'b1, 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'h20},    11};
    vt[3] = '{1, 1, 5,  2, 1'b0, 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'd15},    5};
    vt[4] = '{2, 2, 4,  3, 1'b0, 1'b0, 4, {8'd16, 8'd8, 8'd8, 8'd4},    4};
    vt[5] = '{1, 1, 1,  4, 1'b1, 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'd255},   4};
    vt[6] = '{1, 1, 2,  4, 1'b1, 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'hFE},    4};
    vt[7] = '{1, 1, 2,  4, 1'b0, 1'b0, 1, {8'd0, 8'd0, 8'd0, 8'd255},   4};
    vt[8] = '{2, 2, 2,  0, 1'b0, 1'b1, 4, {8'd4, 8'd3, 8'd2, 8'd1},     4};
    vt[9] = '{1, 3, 32, 3, 1'b0, 1'b0, 3, {8'd0, 8'd96, 8'd64, 8'd32},  11};

    rst = 1'b1; start = 1'b0; complete = 1'b1; val_rows = 1'b0;
    rows_a = '0; cols_b = '0; inner_k = '0; row_in = '0; col_in = '0;
    matA_row = '0; matB_col = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_sat", outs_s, 64'd0);
    chk("reset_outputs_trn", outs_t, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) apply_vec(vt[i], i);

    // rows_a = 0: done two cycles after start, nothing else
    rows_a = DW'(0); cols_b = DW'(2); inner_k = DW'(2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    act = 0; done_at = -1; n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_s.new_request || bus_s.valid_out) act++;
      if (bus_s.done) begin n++; if (done_at < 0) done_at = i; end
      if (i == 0) chk("zero_dim_busy_fin", bus_s.busy, 1);
      if (i == 3) chk("zero_dim_idle", bus_s.busy, 0);
    end
    chk("zero_dim_done_at", done_at, 1);
    chk("zero_dim_done_cnt", n, 1);
    chk("zero_dim_activity", act, 0);

    // start without complete: no activity at all
    complete = 1'b0; rows_a = DW'(2); cols_b = DW'(2); inner_k = DW'(2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_s.new_request || bus_s.valid_out || bus_s.done || bus_s.busy) act++;
    end
    chk("no_complete_activity", act, 0);
    complete = 1'b1;

    // reset during MAC of element (0,1), then a stale response
    run_case('{2, 2, 32, 3, 1'b0, 1'b0, 4, 32'd0, 11}, 1'b1, n);
    chk("rst_elems_before", n, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    val_rows = 1'b1; row_in = AW'(0); col_in = AW'(1);
    matA_row = pack_a(3, 0); matB_col = pack_b(3, 1);
    @(negedge clk);
    chk("rst_mid_outputs", outs_s, 64'd0);
    @(posedge clk); #1 val_rows = 1'b0;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_s.new_request || bus_s.valid_out || bus_s.done || bus_s.busy) act++;
    end
    chk("rst_stale_ignored", act, 0);
    chk("rst_final_outputs", outs_s, 64'd0);
    apply_vec(vt[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
